// File: rtl/pipo_register.sv
// pipo_register: STAGES-deep parallel-in/parallel-out register with synchronous active-low reset.
// Define PIPO_PARITY_EN to add q_par, the even parity of q, registered with the same latency.
module pipo_register #(
    parameter int WIDTH = 4,
    parameter int STAGES = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
`ifdef PIPO_PARITY_EN
    output logic             q_par,
`endif
    output logic [WIDTH-1:0] q
);
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("pipo_register: WIDTH must be 1..64");
    end
    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
        $error("pipo_register: STAGES must be 1..16");
    end
    logic [WIDTH-1:0] rank [STAGES];
    always_ff @(posedge clk) begin
        if (!rst) begin
            rank <= '{default: RESET_VALUE};
        end else begin
            rank[0] <= data;
            for (int i = 1; i < STAGES; i++) rank[i] <= rank[i-1];
        end
    end
    assign q = rank[STAGES-1];
`ifdef PIPO_PARITY_EN
    // parity is computed at the input and carried down its own shift chain
    logic par [STAGES];
    always_ff @(posedge clk) begin
        if (!rst) begin
            par <= '{default: ^RESET_VALUE};
        end else begin
            par[0] <= ^data;
            for (int i = 1; i < STAGES; i++) par[i] <= par[i-1];
        end
    end
    assign q_par = par[STAGES-1];
`endif
endmodule

// File: tb/tb_pipo_register.sv
// tb_pipo_register: checks a 1-stage and a 3-stage pipo_register against a queue scoreboard
// plus the fixed expectations of the test plan.
module tb_pipo_register;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] data = 4'b0000;
    logic [3:0] q1, q3;
    int total = 0;
    int bad = 0;
    logic [3:0] sb1[$];
    logic [3:0] sb3[$];
`ifdef PIPO_PARITY_EN
    logic p1, p3;
    pipo_register #(.WIDTH(4), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .data(data), .q_par(p1), .q(q1));
    pipo_register #(.WIDTH(4), .STAGES(3)) dut3 (.clk(clk), .rst(rst), .data(data), .q_par(p3), .q(q3));
`else
    pipo_register #(.WIDTH(4), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .data(data), .q(q1));
    pipo_register #(.WIDTH(4), .STAGES(3)) dut3 (.clk(clk), .rst(rst), .data(data), .q(q3));
`endif
    always #5 clk = ~clk;

    // drive on the falling edge, update scoreboards at the rising edge, return the words due now
    task automatic step(input logic r, input logic [3:0] d, output logic [3:0] e1, output logic [3:0] e3);
        @(negedge clk);
        rst = r;
        data = d;
        @(posedge clk);
        if (!r) begin
            sb1 = '{4'b0000};
            sb3 = '{4'b0000, 4'b0000, 4'b0000};
        end else begin
            sb1.push_back(d);
            sb3.push_back(d);
        end
        e1 = sb1.pop_front();
        e3 = sb3.pop_front();
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] e1, e3;
        step(1'b0, 4'b1010, e1, e3);
        total++; if (q1 !== 4'b0000) begin bad++; $display("FAIL reset_q1 got=%b want=0000", q1); end
        total++; if (q3 !== 4'b0000) begin bad++; $display("FAIL reset_q3 got=%b want=0000", q3); end
        step(1'b1, 4'b1001, e1, e3);
        total++; if (q1 !== 4'b1001) begin bad++; $display("FAIL load_q1 got=%b want=1001", q1); end
        // a reset pulse that never meets a rising edge must leave q alone
        @(negedge clk);
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (q1 !== 4'b1001) begin bad++; $display("FAIL async_rst_ignored got=%b want=1001", q1); end
        step(1'b0, 4'b1111, e1, e3);
        total++; if (q1 !== e1) begin bad++; $display("FAIL reset_again_q1 got=%b want=%b", q1, e1); end
    endtask

    task automatic test_walking;
        logic [3:0] e1, e3;
        logic [3:0] words [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, words[i], e1, e3);
            total++; if (q1 !== words[i]) begin bad++; $display("FAIL walk_q1[%0d] got=%b want=%b", i, q1, words[i]); end
            total++; if (q3 !== e3) begin bad++; $display("FAIL walk_q3[%0d] got=%b want=%b", i, q3, e3); end
        end
    endtask

    task automatic test_setup_hold;
        logic [3:0] e3;
        @(negedge clk);
        data = 4'b0011;
        #2 data = 4'b0101;
        #1;
        total++; if (q1 === 4'b0011) begin bad++; $display("FAIL glitch_seen got=%b want=not 0011", q1); end
        @(posedge clk);
        sb3.push_back(4'b0101);
        e3 = sb3.pop_front();
        #1;
        total++; if (q1 !== 4'b0101) begin bad++; $display("FAIL setup_hold_q1 got=%b want=0101", q1); end
        total++; if (q3 !== e3) begin bad++; $display("FAIL setup_hold_q3 got=%b want=%b", q3, e3); end
    endtask

    task automatic test_latency;
        logic [3:0] e1, e3;
        logic [3:0] words [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] want3 [5] = '{4'b0101, 4'b0101, 4'b0001, 4'b0010, 4'b0100};
        step(1'b1, 4'b0101, e1, e3);
        step(1'b1, 4'b0101, e1, e3);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, words[i], e1, e3);
            total++; if (q3 !== want3[i]) begin bad++; $display("FAIL latency_q3[%0d] got=%b want=%b", i, q3, want3[i]); end
            total++; if (q3 !== e3) begin bad++; $display("FAIL latency_sb[%0d] got=%b want=%b", i, q3, e3); end
        end
    endtask

    task automatic test_midstream_reset;
        logic [3:0] e1, e3;
        logic [3:0] post [3] = '{4'b0110, 4'b0111, 4'b1011};
        logic [3:0] want3 [3] = '{4'b0000, 4'b0000, 4'b0110};
        step(1'b1, 4'b1001, e1, e3);
        step(1'b1, 4'b1010, e1, e3);
        step(1'b1, 4'b1100, e1, e3);
        total++; if (q3 !== 4'b1001) begin bad++; $display("FAIL full_pipe_q3 got=%b want=1001", q3); end
        step(1'b0, 4'b1111, e1, e3);
        total++; if (q3 !== 4'b0000) begin bad++; $display("FAIL flush_q3 got=%b want=0000", q3); end
        total++; if (q1 !== 4'b0000) begin bad++; $display("FAIL flush_q1 got=%b want=0000", q1); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, post[i], e1, e3);
            total++; if (q3 !== want3[i]) begin bad++; $display("FAIL post_reset_q3[%0d] got=%b want=%b", i, q3, want3[i]); end
            total++; if (q1 !== e1) begin bad++; $display("FAIL post_reset_q1[%0d] got=%b want=%b", i, q1, e1); end
        end
    endtask

`ifdef PIPO_PARITY_EN
    task automatic test_parity;
        logic [3:0] e1, e3;
        step(1'b1, 4'b1111, e1, e3);
        total++; if (p1 !== 1'b0) begin bad++; $display("FAIL par_1111 got=%b want=0", p1); end
        step(1'b1, 4'b0111, e1, e3);
        total++; if (p1 !== 1'b1 || q1 !== 4'b0111) begin bad++; $display("FAIL par_0111 got=%b/%b want=1/0111", p1, q1); end
        step(1'b1, 4'b0000, e1, e3);
        total++; if (p3 !== 1'b0) begin bad++; $display("FAIL par3_1111 got=%b want=0", p3); end
        step(1'b1, 4'b0000, e1, e3);
        total++; if (p3 !== 1'b1) begin bad++; $display("FAIL par3_0111 got=%b want=1", p3); end
        step(1'b0, 4'b0111, e1, e3);
        total++; if (p1 !== 1'b0 || p3 !== 1'b0) begin bad++; $display("FAIL par_reset got=%b/%b want=0/0", p1, p3); end
    endtask
`endif

    initial begin
        test_reset();
        test_walking();
        test_setup_hold();
        test_latency();
        test_midstream_reset();
`ifdef PIPO_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipo_register.md
Name: pipo_register

Overview:
- Parallel-in/parallel-out register. Captures a WIDTH-bit parallel word on every rising clock edge and presents it on a parallel output.
- Used as a generic data-holding or pipeline-delay element between combinational blocks.
- Depth is configurable: STAGES back-to-back register ranks, with a default of one rank.
- Top-level ports are exactly clk, rst, data and q. The optional parity port exists only when the feature macro is defined.

Parameters:
- WIDTH, 4, bit width of data and q; legal range 1..64.
- STAGES, 1, number of register ranks between data and q; legal range 1..16.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into every rank on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low. rst=0 at a rising clk edge resets all ranks.
- data  input  WIDTH  parallel input word.
- q  output  WIDTH  parallel output word, driven directly from the last rank's flops (no combinational path from data).

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low.
- At each rising clk edge with rst=0:
  - every rank, and therefore q, loads RESET_VALUE;
  - data is ignored.
  - Asserting rst with no clock edge has no effect, because reset is synchronous.
- At each rising clk edge with rst=1:
  - rank[0] loads data;
  - rank[i] loads rank[i-1] for i = 1..STAGES-1;
  - q = rank[STAGES-1].
- Latency:
  - q reflects the data sampled STAGES rising edges earlier.
  - With STAGES=1, q equals the data sampled at the most recent rising edge.
- Throughput: one word per cycle. There is no enable and no handshake; every edge loads.
- Power-up before the first reset edge: q is X in simulation. No initial value is required.
- Reset mid-stream:
  - the whole pipeline flushes to RESET_VALUE in one edge;
  - after rst returns to 1, q shows RESET_VALUE until the first post-reset word reaches the output STAGES edges later.
- Data changing between edges does not affect q. Only the value at the rising edge is captured.
- All WIDTH bits are captured independently; no bit-ordering transformation is applied (bit i of data maps to bit i of q).
- Elaboration must fail (e.g. a generate-time error) when WIDTH or STAGES is out of range.

Optional Feature:
- Macro: PIPO_PARITY_EN.
- Defined:
  - adds output port q_par (1 bit) = even parity (XOR reduction) of the word in the last rank;
  - q_par is registered alongside q, with identical latency and reset behaviour;
  - q_par resets to the parity of RESET_VALUE.
- Undefined:
  - q_par port and its logic are absent;
  - the port list is exactly clk, rst, data, q.

Test Plan:
1. Reset: STAGES=1; hold rst=0 and data=4'b1010 over one rising edge -> q=4'b0000 after the edge; data is ignored.
2. Walking pattern: rst=1; data changes on falling edges 0000, 0001, 0010, 0100, 1000, 1111 -> after each subsequent rising edge q equals the word just applied, in that order.
3. Setup/hold: change data mid-cycle twice (0011 then 0101) before one rising edge -> q=0101; q never shows 0011.
4. Latency: STAGES=3; apply 0001, 0010, 0100 on consecutive edges -> q=0001 on the 3rd edge, 0010 on the 4th, 0100 on the 5th.
5. Mid-stream reset: STAGES=3 with a full pipeline; pulse rst=0 for one edge -> q=0000 immediately; q stays 0000 for 2 more edges, then shows the first post-reset word.
6. Parity (PIPO_PARITY_EN defined): data=1111 -> q_par=0; data=0111 -> q_par=1 with q=0111; after reset, q_par=0.
